// File: rtl/dsi.sv
// rtl/dsi.sv - shared constants, FSM state codes and header ECC for the DSI long packet builder
package dsi;

  localparam int FRAME_LENGTH = 8;

  localparam logic [5:0] DT_RGB888 = 6'h3E;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_HDR  = 2'd1;
  localparam state_t ST_PAY  = 2'd2;
  localparam state_t ST_CRC  = 2'd3;

  // DSI packet-header Hamming code over {WC_MSB, WC_LSB, DI}; the top two bits are always zero.
  function automatic logic [7:0] dsi_ecc(input logic [23:0] d);
    logic [7:0] e;
    e[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^
           d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    e[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^
           d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    e[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^
           d[18] ^ d[20] ^ d[21] ^ d[22];
    e[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^
           d[19] ^ d[20] ^ d[21] ^ d[23];
    e[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^
           d[19] ^ d[20] ^ d[22] ^ d[23];
    e[5] = (^d[19:10]) ^ d[21] ^ d[22] ^ d[23];
    e[7:6] = 2'b00;
    return e;
  endfunction

endpackage

// File: rtl/dsi_crc16.sv
// rtl/dsi_crc16.sv - byte-wide reflected CRC-16 (0x8408), seed 0xFFFF, no final XOR
module dsi_crc16 (
  input  logic        pclk_i,
  input  logic        rst_ni,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;
  logic [15:0] step;

  // Fold one byte in LSB-first; init wins over enable so a new packet always starts from the seed.
  always_comb begin
    step = crc_q ^ {8'h00, data_i};
    for (int i = 0; i < 8; i++) begin
      step = step[0] ? ((step >> 1) ^ 16'h8408) : (step >> 1);
    end
    crc_d = crc_q;
    if (init_i) begin
      crc_d = 16'hFFFF;
    end else if (en_i) begin
      crc_d = step;
    end
  end

  // CRC register, seeded on reset.
  always_ff @(posedge pclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q <= 16'hFFFF;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/dsi_long_pkt_builder.sv
// rtl/dsi_long_pkt_builder.sv - captures a line and serialises it as a DSI long packet byte stream
module dsi_long_pkt_builder
  import dsi::*;
#(
  parameter int LINE_PIXELS = FRAME_LENGTH,
  parameter int MAX_BYTES   = LINE_PIXELS * 3
) (
  input  logic                      pclk,
  input  logic                      rst_n,
  input  logic [15:0]               WC,
  input  logic [LINE_PIXELS*24-1:0] payload,
  input  logic                      fifo_done,
  input  logic [1:0]                vc,
  input  logic [5:0]                data_type,
  output logic [7:0]                pkt_byte,
  output logic                      pkt_valid,
  input  logic                      pkt_ready,
  output logic                      pkt_sop,
  output logic                      pkt_eop,
  output logic                      busy,
  output logic                      overrun,
  output logic                      wc_err
);

  localparam int          NBYTES = LINE_PIXELS * 3;
  localparam int          AW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [15:0] MAX_WC = 16'(MAX_BYTES);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] wc_q, wc_d;
  logic [7:0]  di_q, di_d;
  logic [7:0]  ecc_q, ecc_d;
  logic [7:0]  buf_q [NBYTES];
  logic        overrun_q, overrun_d;
  logic        wc_err_q, wc_err_d;

  logic        accept;
  logic        eop_w;
  logic        capture;
  logic [15:0] wc_eff;
  logic [7:0]  di_in;
  logic [7:0]  pay_byte;
  logic [15:0] crc;

  assign busy      = (state_q != ST_IDLE);
  assign pkt_valid = busy;
  assign accept    = pkt_valid && pkt_ready;
  assign eop_w     = (state_q == ST_CRC) && (cnt_q == 16'd1);
  // The EOP-accept edge frees the builder, so a line arriving then starts the next packet without a gap.
  assign capture   = fifo_done && ((state_q == ST_IDLE) || (eop_w && accept));
  assign wc_eff    = (WC > MAX_WC) ? MAX_WC : WC;
  assign di_in     = {vc, data_type};
  assign pay_byte  = buf_q[cnt_q[AW-1:0]];
  assign overrun   = overrun_q;
  assign wc_err    = wc_err_q;
  assign pkt_sop   = (state_q == ST_HDR) && (cnt_q == 16'd0);
  assign pkt_eop   = eop_w;

  dsi_crc16 u_crc (
    .pclk_i (pclk),
    .rst_ni (rst_n),
    .init_i (capture),
    .en_i   (accept && (state_q == ST_PAY)),
    .data_i (pay_byte),
    .crc_o  (crc)
  );

  // Output byte mux: everything comes from registers, so it holds naturally across stalls.
  always_comb begin
    pkt_byte = 8'h00;
    case (state_q)
      ST_HDR: begin
        case (cnt_q[1:0])
          2'd0:    pkt_byte = di_q;
          2'd1:    pkt_byte = wc_q[7:0];
          2'd2:    pkt_byte = wc_q[15:8];
          default: pkt_byte = ecc_q;
        endcase
      end
      ST_PAY:  pkt_byte = pay_byte;
      ST_CRC:  pkt_byte = cnt_q[0] ? crc[15:8] : crc[7:0];
      default: pkt_byte = 8'h00;
    endcase
  end

  // Sequencing: header -> payload (skipped when WC is zero) -> footer, advancing only on accepted bytes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wc_d      = wc_q;
    di_d      = di_q;
    ecc_d     = ecc_q;
    overrun_d = fifo_done && busy && !(eop_w && accept);
    wc_err_d  = capture && (WC > MAX_WC);
    if (accept) begin
      case (state_q)
        ST_HDR: begin
          if (cnt_q == 16'd3) begin
            cnt_d   = 16'd0;
            state_d = (wc_q == 16'd0) ? ST_CRC : ST_PAY;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_PAY: begin
          if (cnt_q == wc_q - 16'd1) begin
            cnt_d   = 16'd0;
            state_d = ST_CRC;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_CRC: begin
          if (cnt_q == 16'd1) begin
            cnt_d   = 16'd0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
        end
      endcase
    end
    if (capture) begin
      state_d = ST_HDR;
      cnt_d   = 16'd0;
      wc_d    = wc_eff;
      di_d    = di_in;
      ecc_d   = dsi_ecc({wc_eff, di_in});
    end
  end

  // State, header fields, pulse flags and the line buffer; reset aborts any packet in flight.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 16'd0;
      wc_q      <= 16'd0;
      di_q      <= 8'h00;
      ecc_q     <= 8'h00;
      overrun_q <= 1'b0;
      wc_err_q  <= 1'b0;
      for (int k = 0; k < NBYTES; k++) begin
        buf_q[k] <= 8'h00;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wc_q      <= wc_d;
      di_q      <= di_d;
      ecc_q     <= ecc_d;
      overrun_q <= overrun_d;
      wc_err_q  <= wc_err_d;
      if (capture) begin
        for (int k = 0; k < NBYTES; k++) begin
          buf_q[k] <= payload[k*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dsi_long_pkt_builder.sv
// tb/tb_dsi_long_pkt_builder.sv - scoreboard bench for dsi_long_pkt_builder
module tb_dsi_long_pkt_builder;
  import dsi::*;

  localparam int NB = FRAME_LENGTH * 3;

  typedef logic [7:0] bytes_t [NB];
  typedef struct packed {
    logic [7:0] b;
    logic       sop;
    logic       eop;
  } exp_t;

  // Parity masks: bit i of mask p is set when D[i] participates in parity bit p.
  localparam logic [23:0] ECC_MASK [6] = '{24'hF12CB7, 24'hF2555B, 24'h749A6D,
                                           24'hB8E38E, 24'hDF03F0, 24'hEFFC00};

  logic          pclk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   wc = 16'd0;
  logic [NB*8-1:0] payload = '0;
  logic          fifo_done = 1'b0;
  logic [1:0]    vc = 2'd0;
  logic [5:0]    data_type = DT_RGB888;
  logic [7:0]    pkt_byte;
  logic          pkt_valid;
  logic          pkt_ready = 1'b1;
  logic          pkt_sop, pkt_eop, busy, overrun, wc_err;

  exp_t          exp_q [$];
  logic [7:0]    got_q [$];
  int            checks = 0;
  int            failures = 0;
  int            ovr_cnt = 0;
  int            wce_cnt = 0;
  int            vcyc = 0;
  int            ready_mode = 0;

  dsi_long_pkt_builder dut (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .WC        (wc),
    .payload   (payload),
    .fifo_done (fifo_done),
    .vc        (vc),
    .data_type (data_type),
    .pkt_byte  (pkt_byte),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_sop   (pkt_sop),
    .pkt_eop   (pkt_eop),
    .busy      (busy),
    .overrun   (overrun),
    .wc_err    (wc_err)
  );

  always #5 pclk = ~pclk;

  // Downstream ready: constant 1, or a random pattern when stalls are being exercised.
  always @(posedge pclk) begin
    #1;
    pkt_ready = (ready_mode != 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Monitor: pops the scoreboard on every accepted byte and checks stall stability.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_b = 8'h00;
  logic       prev_s = 1'b0, prev_e = 1'b0;
  always @(negedge pclk) begin
    exp_t e;
    if (rst_n) begin
      if (overrun) ovr_cnt++;
      if (wc_err)  wce_cnt++;
      if (pkt_valid) vcyc++;
      if (prev_stall) begin
        checks++;
        if ({pkt_valid, pkt_byte, pkt_sop, pkt_eop} !== {1'b1, prev_b, prev_s, prev_e}) begin
          failures++;
          $display("FAIL stall_hold got v=%b b=%h s=%b e=%b required v=1 b=%h s=%b e=%b",
                   pkt_valid, pkt_byte, pkt_sop, pkt_eop, prev_b, prev_s, prev_e);
        end
      end
      if (pkt_valid && pkt_ready) begin
        got_q.push_back(pkt_byte);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_byte got=%h sop=%b eop=%b required=none", pkt_byte, pkt_sop, pkt_eop);
        end else begin
          e = exp_q.pop_front();
          if ({pkt_byte, pkt_sop, pkt_eop} !== {e.b, e.sop, e.eop}) begin
            failures++;
            $display("FAIL byte_stream got=%h sop=%b eop=%b required=%h sop=%b eop=%b",
                     pkt_byte, pkt_sop, pkt_eop, e.b, e.sop, e.eop);
          end
        end
      end
      prev_stall = pkt_valid && !pkt_ready;
      prev_b = pkt_byte;
      prev_s = pkt_sop;
      prev_e = pkt_eop;
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic logic [7:0] model_ecc(input logic [23:0] d);
    logic [7:0] r;
    r = 8'h00;
    for (int p = 0; p < 6; p++) r[p] = ^(d & ECC_MASK[p]);
    return r;
  endfunction

  // Reference packet: header, clamped payload, then a bit-serial CRC over the payload.
  task automatic push_model(input int wc_in, input logic [1:0] v, input logic [5:0] dt,
                            input bytes_t pl);
    int          w;
    logic [15:0] w16;
    logic [23:0] d;
    logic [15:0] c;
    logic        fb;
    w   = (wc_in > NB) ? NB : wc_in;
    w16 = w[15:0];
    d   = {w16, v, dt};
    exp_q.push_back('{b: d[7:0], sop: 1'b1, eop: 1'b0});
    exp_q.push_back('{b: d[15:8], sop: 1'b0, eop: 1'b0});
    exp_q.push_back('{b: d[23:16], sop: 1'b0, eop: 1'b0});
    exp_q.push_back('{b: model_ecc(d), sop: 1'b0, eop: 1'b0});
    c = 16'hFFFF;
    for (int k = 0; k < w; k++) begin
      exp_q.push_back('{b: pl[k], sop: 1'b0, eop: 1'b0});
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ pl[k][j];
        c  = c >> 1;
        if (fb) c = c ^ 16'h8408;
      end
    end
    exp_q.push_back('{b: c[7:0], sop: 1'b0, eop: 1'b0});
    exp_q.push_back('{b: c[15:8], sop: 1'b0, eop: 1'b1});
  endtask

  function automatic logic [NB*8-1:0] to_bus(input bytes_t pl);
    logic [NB*8-1:0] r;
    for (int k = 0; k < NB; k++) r[k*8 +: 8] = pl[k];
    return r;
  endfunction

  function automatic bytes_t rand_bytes();
    bytes_t r;
    for (int k = 0; k < NB; k++) r[k] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  // Called at posedge+1; fifo_done is sampled by the next edge.
  task automatic send(input int wc_in, input logic [1:0] v, input logic [5:0] dt,
                      input bytes_t pl, input bit expect_pkt);
    wc        = 16'(wc_in);
    vc        = v;
    data_type = dt;
    payload   = to_bus(pl);
    fifo_done = 1'b1;
    if (expect_pkt) push_model(wc_in, v, dt, pl);
    @(posedge pclk);
    #1;
    fifo_done = 1'b0;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", nm, got, req);
    end
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(posedge pclk);
      #1;
      n++;
    end
    check({nm, "_drain"}, {31'd0, (exp_q.size() != 0 || busy)}, 32'd0);
  endtask

  task automatic check_got(input string nm, input logic [7:0] lit [$]);
    check({nm, "_len"}, got_q.size(), lit.size());
    for (int k = 0; k < lit.size() && k < got_q.size(); k++)
      check($sformatf("%s_b%0d", nm, k), {24'd0, got_q[k]}, {24'd0, lit[k]});
  endtask

  initial begin
    bytes_t     pl;
    logic [7:0] lit [$];
    int         o0, w0, v0, n, wcr, exp_wce;

    pl = rand_bytes();
    repeat (3) @(posedge pclk);
    #1;
    check("reset_outputs", {18'd0, pkt_byte, pkt_valid, pkt_sop, pkt_eop, busy, overrun, wc_err}, 32'd0);
    rst_n = 1'b1;
    @(posedge pclk);
    #1;

    // 1: "123456789" reference packet, ready held high
    for (int k = 0; k < 9; k++) pl[k] = 8'h31 + 8'(k);
    got_q.delete();
    v0 = vcyc;
    send(9, 2'd0, DT_RGB888, pl, 1'b1);
    check("first_byte_latency", {29'd0, pkt_valid, pkt_sop, busy}, 32'd7);
    wait_drain("t1");
    lit = {8'h3E, 8'h09, 8'h00, 8'h31, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
           8'h36, 8'h37, 8'h38, 8'h39, 8'h91, 8'h6F};
    check_got("t1", lit);
    check("t1_valid_cycles", vcyc - v0, 15);

    // 2: WC=3 header
    got_q.delete();
    send(3, 2'd0, DT_RGB888, pl, 1'b1);
    wait_drain("t2");
    check("t2_ecc", {24'd0, got_q[3]}, 32'h08);

    // 3: empty payload
    got_q.delete();
    send(0, 2'd0, DT_RGB888, pl, 1'b1);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge pclk);
      n++;
    end
    @(posedge pclk);
    #1;
    check("t3_busy_after_eop", {31'd0, busy}, 32'd0);
    lit = {8'h3E, 8'h00, 8'h00, 8'h0E, 8'hFF, 8'hFF};
    check_got("t3", lit);

    // 4: same reference packet under random back-pressure
    got_q.delete();
    ready_mode = 1;
    send(9, 2'd0, DT_RGB888, pl, 1'b1);
    wait_drain("t4");
    ready_mode = 0;
    lit = {8'h3E, 8'h09, 8'h00, 8'h31, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
           8'h36, 8'h37, 8'h38, 8'h39, 8'h91, 8'h6F};
    check_got("t4", lit);

    // 5a: line arriving mid-payload is dropped
    o0 = ovr_cnt;
    send(20, 2'd1, 6'h24, rand_bytes(), 1'b1);
    repeat (8) begin
      @(posedge pclk);
      #1;
    end
    send(7, 2'd2, 6'h11, rand_bytes(), 1'b0);
    wait_drain("t5a");
    repeat (4) @(posedge pclk);
    #1;
    check("t5a_overrun_count", ovr_cnt - o0, 1);
    check("t5a_no_second_pkt", {31'd0, pkt_valid}, 32'd0);

    // 5b: line arriving on the EOP-accept cycle starts the next packet immediately
    o0 = ovr_cnt;
    send(5, 2'd3, 6'h3E, rand_bytes(), 1'b1);
    n = 0;
    while (!(pkt_valid && pkt_ready && pkt_eop) && n < 200) begin
      @(negedge pclk);
      n++;
    end
    check("t5b_eop_seen", {31'd0, pkt_eop}, 32'd1);
    pl        = rand_bytes();
    wc        = 16'd4;
    vc        = 2'd1;
    data_type = 6'h3E;
    payload   = to_bus(pl);
    fifo_done = 1'b1;
    push_model(4, 2'd1, 6'h3E, pl);
    @(posedge pclk);
    #1;
    fifo_done = 1'b0;
    check("t5b_sop_next_cycle", {30'd0, pkt_valid, pkt_sop}, 32'd3);
    wait_drain("t5b");
    @(posedge pclk);
    #1;
    check("t5b_no_overrun", ovr_cnt - o0, 0);

    // 6a: oversize WC is clamped
    w0 = wce_cnt;
    got_q.delete();
    send(NB + 5, 2'd0, DT_RGB888, rand_bytes(), 1'b1);
    wait_drain("t6a");
    check("t6a_wc_err_count", wce_cnt - w0, 1);
    check("t6a_hdr_wc", {16'd0, got_q[2], got_q[1]}, NB);

    // 6b: reset mid-payload aborts, next line is clean
    send(20, 2'd0, DT_RGB888, rand_bytes(), 1'b1);
    repeat (8) begin
      @(posedge pclk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("t6b_async_reset", {18'd0, pkt_byte, pkt_valid, pkt_sop, pkt_eop, busy, overrun, wc_err}, 32'd0);
    exp_q.delete();
    @(posedge pclk);
    #2;
    rst_n = 1'b1;
    @(posedge pclk);
    #1;
    send(11, 2'd2, 6'h3E, rand_bytes(), 1'b1);
    wait_drain("t6b");

    // Random packets, with and without back-pressure
    w0 = wce_cnt;
    exp_wce = 0;
    for (int i = 0; i < 8; i++) begin
      ready_mode = i % 2;
      wcr = $urandom_range(0, NB + 3);
      if (wcr > NB) exp_wce++;
      send(wcr, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), rand_bytes(), 1'b1);
      wait_drain($sformatf("rnd%0d", i));
    end
    ready_mode = 0;
    @(posedge pclk);
    #1;
    check("rnd_wc_err_count", wce_cnt - w0, exp_wce);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
